// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the memory access unit: word width, op codes,
// FSM state encoding and the alignment-fault rule.
package mem_access_unit_pkg;

  localparam int WORD_WIDTH = 32;
  localparam logic [WORD_WIDTH-1:0] ZERO_WORD = '0;

  // Loads occupy the low codes so "is a load" is a single compare.
  typedef enum logic [2:0] {
    OP_LB  = 3'd0,
    OP_LBU = 3'd1,
    OP_LH  = 3'd2,
    OP_LHU = 3'd3,
    OP_LW  = 3'd4,
    OP_SB  = 3'd5,
    OP_SH  = 3'd6,
    OP_SW  = 3'd7
  } mem_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_MERGE = 2'd2
  } mau_state_e;

  function automatic logic is_load(mem_op_e op);
    return (op <= OP_LW);
  endfunction

  // Halfword accesses need an even address, word accesses a multiple of 4.
  function automatic logic is_misaligned(mem_op_e op, logic [1:0] off);
    case (op)
      OP_LH, OP_LHU, OP_SH: return off[0];
      OP_LW, OP_SW:         return (off != 2'b00);
      default:              return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_load_align.sv
// Selects the addressed byte/halfword of a big-endian word and extends it.
module load_align
  import mem_access_unit_pkg::*;
#(
  parameter int W = WORD_WIDTH
) (
  input  logic [W-1:0] word,
  input  logic [1:0]   offset,
  input  logic [2:0]   op,
  output logic [W-1:0] data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Offset 0 is the most significant lane; offset[0] is ignored for halfwords.
  always_comb begin
    byte_lane = word[{~offset, 3'b000} +: 8];
    half_lane = word[{~offset[1], 4'b0000} +: 16];
    case (mem_op_e'(op))
      OP_LB:   data = {{(W-8){byte_lane[7]}}, byte_lane};
      OP_LBU:  data = {{(W-8){1'b0}}, byte_lane};
      OP_LH:   data = {{(W-16){half_lane[15]}}, half_lane};
      OP_LHU:  data = {{(W-16){1'b0}}, half_lane};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory access unit: turns pipeline byte/half/word loads and stores into
// word-wide data memory accesses. Sub-word stores are read-modify-write.
//
// Handshake: a request is taken in any cycle where req_valid=1 and busy=0;
// there is no separate ready. While busy=1 the pipeline must hold its request
// and req_valid is ignored. resp_valid marks the single completion cycle.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int W = WORD_WIDTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  input  logic [2:0]   req_op,
  input  logic [W-1:0] req_addr,
  input  logic [W-1:0] req_wdata,
  output logic         busy,
  output logic         resp_valid,
  output logic [W-1:0] load_data,
  output logic         misalign,
  output logic [W-1:0] err_addr,
  output logic         read_en,
  output logic [W-1:0] read_addr,
  input  logic [W-1:0] read_data,
  output logic         write_en,
  output logic [W-1:0] write_addr,
  output logic [W-1:0] write_data,
  output logic [1:0]   dbg_state
);

  mau_state_e   state_q;
  mem_op_e      op_q;
  logic [W-1:0] addr_q;
  logic [W-1:0] wdata_q;

  mem_op_e      req_op_e;
  logic [W-1:0] req_word_addr;
  logic [W-1:0] aligned_data;
  logic [W-1:0] merged_word;
  logic [4:0]   lane_shift;
  logic [W-1:0] lane_mask;

  assign req_op_e      = mem_op_e'(req_op);
  assign req_word_addr = {req_addr[W-1:2], 2'b00};
  assign dbg_state     = state_q;

  load_align #(.W(W)) u_load_align (
    .word   (read_data),
    .offset (addr_q[1:0]),
    .op     (op_q),
    .data   (aligned_data)
  );

  // Store merge: replace the addressed big-endian lane of the read word.
  always_comb begin
    if (op_q == OP_SB) begin
      lane_shift = {~addr_q[1:0], 3'b000};
      lane_mask  = {{(W-8){1'b0}}, 8'hFF};
    end else begin
      lane_shift = {~addr_q[1], 4'b0000};
      lane_mask  = {{(W-16){1'b0}}, 16'hFFFF};
    end
    merged_word = (read_data & ~(lane_mask << lane_shift))
                | ((wdata_q & lane_mask) << lane_shift);
  end

  // Output decode from state and the incoming request; everything quiet in reset.
  always_comb begin
    busy       = 1'b0;
    resp_valid = 1'b0;
    load_data  = ZERO_WORD;
    misalign   = 1'b0;
    read_en    = 1'b0;
    read_addr  = ZERO_WORD;
    write_en   = 1'b0;
    write_addr = ZERO_WORD;
    write_data = ZERO_WORD;
    if (!rst) begin
      busy = (state_q != ST_IDLE);
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            if (is_misaligned(req_op_e, req_addr[1:0])) begin
              resp_valid = 1'b1;
              misalign   = 1'b1;
            end else if (req_op_e == OP_SW) begin
              write_en   = 1'b1;
              write_addr = req_word_addr;
              write_data = req_wdata;
              resp_valid = 1'b1;
            end else begin
              read_en   = 1'b1;
              read_addr = req_word_addr;
            end
          end
        end
        ST_LOAD: begin
          resp_valid = 1'b1;
          load_data  = aligned_data;
        end
        ST_MERGE: begin
          write_en   = 1'b1;
          write_addr = {addr_q[W-1:2], 2'b00};
          write_data = merged_word;
          resp_valid = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // FSM and request latches; a reset mid-access drops the pending access.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_LB;
      addr_q   <= ZERO_WORD;
      wdata_q  <= ZERO_WORD;
      err_addr <= ZERO_WORD;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            if (is_misaligned(req_op_e, req_addr[1:0])) begin
              err_addr <= req_addr;
            end else if (is_load(req_op_e)) begin
              op_q    <= req_op_e;
              addr_q  <= req_addr;
              state_q <= ST_LOAD;
            end else if (req_op_e != OP_SW) begin
              op_q    <= req_op_e;
              addr_q  <= req_addr;
              wdata_q <= req_wdata;
              state_q <= ST_MERGE;
            end
          end
        end
        ST_LOAD:  state_q <= ST_IDLE;
        ST_MERGE: state_q <= ST_IDLE;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a small word-addressed data memory.
module tb_mem_access_unit;

  localparam logic [2:0] LB = 3'd0, LBU = 3'd1, LH = 3'd2, LHU = 3'd3,
                         LW = 3'd4, SB = 3'd5, SH = 3'd6, SW = 3'd7;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        busy;
  logic        resp_valid;
  logic [31:0] load_data;
  logic        misalign;
  logic [31:0] err_addr;
  logic        read_en;
  logic [31:0] read_addr;
  logic [31:0] read_data;
  logic        write_en;
  logic [31:0] write_addr;
  logic [31:0] write_data;
  logic [1:0]  dbg_state;

  logic [31:0] mem [0:255];
  logic        poke_en;
  logic [7:0]  poke_idx;
  logic [31:0] poke_data;

  int checks;
  int errors;

  mem_access_unit #(.W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_op     (req_op),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .busy       (busy),
    .resp_valid (resp_valid),
    .load_data  (load_data),
    .misalign   (misalign),
    .err_addr   (err_addr),
    .read_en    (read_en),
    .read_addr  (read_addr),
    .read_data  (read_data),
    .write_en   (write_en),
    .write_addr (write_addr),
    .write_data (write_data),
    .dbg_state  (dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory: registered read, word write, plus a bench preload port.
  always @(posedge clk) begin
    if (poke_en) mem[poke_idx] <= poke_data;
    if (write_en) mem[write_addr[9:2]] <= write_data;
    if (read_en) read_data <= mem[read_addr[9:2]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply a request at the falling edge, then settle before sampling.
  task automatic step(input logic v, input logic [2:0] op, input logic [31:0] a,
                      input logic [31:0] d);
    @(negedge clk);
    req_valid = v;
    req_op    = op;
    req_addr  = a;
    req_wdata = d;
    #1;
  endtask

  task automatic poke(input logic [7:0] idx, input logic [31:0] d);
    @(negedge clk);
    req_valid = 1'b0;
    poke_en   = 1'b1;
    poke_idx  = idx;
    poke_data = d;
    @(negedge clk);
    poke_en = 1'b0;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    poke_en   = 1'b0;
    poke_idx  = 8'h00;
    poke_data = 32'h0;
    read_data = 32'h0;
    rst       = 1'b1;

    // Reset with a request pending: nothing may leave the unit.
    step(1'b1, LW, 32'h100, 32'h0);
    step(1'b1, LW, 32'h100, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_read_en", {31'h0, read_en}, 32'h0);
    chk("rst_write_en", {31'h0, write_en}, 32'h0);
    chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    req_valid = 1'b0;
    #1;
    chk("rst_state", {30'h0, dbg_state}, 32'h0);
    chk("rst_err_addr", err_addr, 32'h0);
    chk("idle_load_data", load_data, 32'h0);
    chk("idle_misalign", {31'h0, misalign}, 32'h0);

    // LB 0x101 from 0x11223344
    poke(8'h40, 32'h11223344);
    step(1'b1, LB, 32'h101, 32'h0);
    chk("lb_read_en", {31'h0, read_en}, 32'h1);
    chk("lb_read_addr", read_addr, 32'h100);
    chk("lb_resp_c0", {31'h0, resp_valid}, 32'h0);
    step(1'b0, LB, 32'h0, 32'h0);
    chk("lb_resp_c1", {31'h0, resp_valid}, 32'h1);
    chk("lb_busy_c1", {31'h0, busy}, 32'h1);
    chk("lb_data", load_data, 32'h00000022);

    // LB 0x100 sign extension from 0x80FF0000, LBU of the same lane
    poke(8'h40, 32'h80FF0000);
    step(1'b1, LB, 32'h100, 32'h0);
    step(1'b0, LB, 32'h0, 32'h0);
    chk("lb_sext", load_data, 32'hFFFFFF80);
    step(1'b1, LBU, 32'h100, 32'h0);
    step(1'b0, LB, 32'h0, 32'h0);
    chk("lbu_zext", load_data, 32'h00000080);

    // SB 0x102 wdata 0xAB: read, then merged write
    poke(8'h40, 32'h11223344);
    step(1'b1, SB, 32'h102, 32'hFFFFFFAB);
    chk("sb_read_en", {31'h0, read_en}, 32'h1);
    chk("sb_write_en_c0", {31'h0, write_en}, 32'h0);
    chk("sb_write_addr_c0", write_addr, 32'h0);
    step(1'b0, LB, 32'h0, 32'h0);
    chk("sb_busy_c1", {31'h0, busy}, 32'h1);
    chk("sb_write_en_c1", {31'h0, write_en}, 32'h1);
    chk("sb_write_addr", write_addr, 32'h100);
    chk("sb_write_data", write_data, 32'h1122AB44);
    chk("sb_resp_c1", {31'h0, resp_valid}, 32'h1);
    step(1'b0, LB, 32'h0, 32'h0);
    chk("sb_mem", mem[8'h40], 32'h1122AB44);

    // SW 0x200 completes in the acceptance cycle
    step(1'b1, SW, 32'h200, 32'hDEADBEEF);
    chk("sw_write_en", {31'h0, write_en}, 32'h1);
    chk("sw_write_addr", write_addr, 32'h200);
    chk("sw_write_data", write_data, 32'hDEADBEEF);
    chk("sw_resp", {31'h0, resp_valid}, 32'h1);
    chk("sw_busy", {31'h0, busy}, 32'h0);
    chk("sw_read_en", {31'h0, read_en}, 32'h0);
    step(1'b1, LHU, 32'h202, 32'h0);
    chk("lhu_read_en", {31'h0, read_en}, 32'h1);
    step(1'b0, LB, 32'h0, 32'h0);
    chk("lhu_data", load_data, 32'h0000BEEF);
    step(1'b1, LH, 32'h200, 32'h0);
    step(1'b0, LB, 32'h0, 32'h0);
    chk("lh_data", load_data, 32'hFFFFDEAD);
    step(1'b1, LB, 32'h203, 32'h0);
    step(1'b0, LB, 32'h0, 32'h0);
    chk("lb_off3", load_data, 32'hFFFFFFEF);

    // Misaligned LW 0x103 and SH 0x101
    step(1'b1, LW, 32'h103, 32'h0);
    chk("lw_mis_flag", {31'h0, misalign}, 32'h1);
    chk("lw_mis_resp", {31'h0, resp_valid}, 32'h1);
    chk("lw_mis_read_en", {31'h0, read_en}, 32'h0);
    chk("lw_mis_load_data", load_data, 32'h0);
    step(1'b0, LB, 32'h0, 32'h0);
    chk("lw_mis_err_addr", err_addr, 32'h103);
    chk("lw_mis_state", {30'h0, dbg_state}, 32'h0);
    step(1'b1, SH, 32'h101, 32'h1234);
    chk("sh_mis_flag", {31'h0, misalign}, 32'h1);
    chk("sh_mis_read_en", {31'h0, read_en}, 32'h0);
    chk("sh_mis_write_en", {31'h0, write_en}, 32'h0);
    step(1'b0, LB, 32'h0, 32'h0);
    chk("sh_mis_err_addr", err_addr, 32'h101);
    chk("sh_mis_mem", mem[8'h40], 32'h1122AB44);

    // SH 0x200 interrupted by reset in MERGE
    step(1'b1, SH, 32'h200, 32'h1234);
    chk("shr_read_en", {31'h0, read_en}, 32'h1);
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("shr_write_en", {31'h0, write_en}, 32'h0);
    chk("shr_resp", {31'h0, resp_valid}, 32'h0);
    chk("shr_busy", {31'h0, busy}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    req_valid = 1'b1;
    req_op = LW;
    req_addr = 32'h200;
    #1;
    chk("shr_state", {30'h0, dbg_state}, 32'h0);
    chk("shr_mem", mem[8'h80], 32'hDEADBEEF);
    chk("shr_next_accept", {31'h0, read_en}, 32'h1);
    step(1'b0, LB, 32'h0, 32'h0);
    chk("shr_next_data", load_data, 32'hDEADBEEF);

    // Back-to-back LW held by the pipeline: 2-cycle spacing
    step(1'b1, LW, 32'h100, 32'h0);
    chk("b2b_read_c0", {31'h0, read_en}, 32'h1);
    step(1'b1, LW, 32'h100, 32'h0);
    chk("b2b_read_c1", {31'h0, read_en}, 32'h0);
    chk("b2b_busy_c1", {31'h0, busy}, 32'h1);
    chk("b2b_resp_c1", {31'h0, resp_valid}, 32'h1);
    chk("b2b_data_c1", load_data, 32'h1122AB44);
    step(1'b1, LW, 32'h200, 32'h0);
    chk("b2b_read_c2", {31'h0, read_en}, 32'h1);
    chk("b2b_addr_c2", read_addr, 32'h200);
    chk("b2b_resp_c2", {31'h0, resp_valid}, 32'h0);
    step(1'b0, LB, 32'h0, 32'h0);
    chk("b2b_resp_c3", {31'h0, resp_valid}, 32'h1);
    chk("b2b_data_c3", load_data, 32'hDEADBEEF);

    // SH 0x102 merge into the low halfword
    step(1'b1, SH, 32'h102, 32'hFFFF5566);
    step(1'b0, LB, 32'h0, 32'h0);
    chk("sh_write_data", write_data, 32'h11225566);
    step(1'b0, LB, 32'h0, 32'h0);
    chk("sh_mem", mem[8'h40], 32'h11225566);
    chk("sh_after_write_en", {31'h0, write_en}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
